// File: rtl/count_checker_pkg.sv
// Shared types, default sizes and the modulo-increment helper for count_checker.
package count_checker_pkg;

    // Checker FSM states
    typedef enum logic [1:0] {
        StIdle,
        StAcquire,
        StLocked
    } state_e;

    localparam int unsigned DefWidth   = 4;
    localparam int unsigned DefLockRun = 3;
    localparam int unsigned DefStatW   = 8;

    // Value that should follow prev on a free-running up-counter of the given width.
    // Callers narrow the 32-bit result to their own width.
    function automatic logic [31:0] next_count(input logic [31:0] prev,
                                               input int unsigned width);
        logic [31:0] mask;
        mask = (width >= 32) ? '1 : ((32'd1 << width) - 32'd1);
        return (prev + 32'd1) & mask;
    endfunction

endpackage

// File: rtl/count_checker_sat_counter.sv
// Saturating event counter: counts inc pulses, sticks at all-ones, synchronous clear.
module sat_counter #(
    parameter int unsigned W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clear,
    input  logic         inc,
    output logic [W-1:0] value
);

    logic [W-1:0] value_d, value_q;

    // Next value: clear wins, otherwise increment until full
    always_comb begin
        value_d = value_q;
        if (clear) begin
            value_d = '0;
        end else if (inc && (value_q != '1)) begin
            value_d = value_q + 1'b1;
        end
    end

    // Counter register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            value_q <= '0;
        end else begin
            value_q <= value_d;
        end
    end

    assign value = value_q;

endmodule

// File: rtl/count_checker.sv
// count_checker: locks onto a +1 mod 2^WIDTH count sequence and flags deviations.
// Optional feature macro: COUNT_CHECKER_STALL_EN (a repeated sample is a stall, not an error,
// and is reported on stall_pulse).
module count_checker
    import count_checker_pkg::*;
#(
    parameter int unsigned WIDTH    = DefWidth,
    parameter int unsigned LOCK_RUN = DefLockRun,
    parameter int unsigned STAT_W   = DefStatW
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic [WIDTH-1:0]  count_in,
    input  logic              clear,
    output logic              locked,
    output logic              err_pulse,
    output logic [STAT_W-1:0] err_count,
    output logic [STAT_W-1:0] wrap_count,
    output logic [WIDTH-1:0]  expected
`ifdef COUNT_CHECKER_STALL_EN
    ,
    output logic              stall_pulse
`endif
);

    // LOCK_RUN is limited to 1..15
    localparam int unsigned RunW = 4;

    state_e           state_d, state_q;
    logic [RunW-1:0]  run_d, run_q;
    logic [RunW-1:0]  run_inc;
    logic [WIDTH-1:0] prev_d, prev_q;
    logic [WIDTH-1:0] prev_plus;
    logic [WIDTH-1:0] expected_d, expected_q;
    logic             locked_d, locked_q;
    logic             err_d, err_q;
    logic             err_inc, wrap_inc;
    logic             is_match, is_stall;
`ifdef COUNT_CHECKER_STALL_EN
    logic             stall_d, stall_q;
`endif

    assign prev_plus = WIDTH'(next_count(32'(prev_q), WIDTH));
    assign run_inc   = run_q + 4'd1;
    assign is_match  = (count_in == prev_plus);
`ifdef COUNT_CHECKER_STALL_EN
    assign is_stall  = (count_in == prev_q);
`else
    assign is_stall  = 1'b0;
`endif

    // Next-state and registered-output logic; clear overrides any sample this cycle
    always_comb begin
        state_d    = state_q;
        run_d      = run_q;
        prev_d     = prev_q;
        expected_d = expected_q;
        err_d      = 1'b0;
        err_inc    = 1'b0;
        wrap_inc   = 1'b0;
        if (clear) begin
            state_d = StIdle;
            run_d   = '0;
        end else if (en) begin
            prev_d     = count_in;
            expected_d = WIDTH'(next_count(32'(count_in), WIDTH));
            case (state_q)
                StIdle: begin
                    state_d = StAcquire;
                    run_d   = '0;
                end
                StAcquire: begin
                    if (is_stall) begin
                        // hold state and run
                    end else if (is_match) begin
                        run_d = run_inc;
                        if (run_inc == RunW'(LOCK_RUN)) begin
                            state_d = StLocked;
                        end
                    end else begin
                        run_d = '0;
                    end
                end
                StLocked: begin
                    if (is_stall) begin
                        // hold state and run
                    end else if (is_match) begin
                        wrap_inc = (count_in == '0);
                    end else begin
                        err_d   = 1'b1;
                        err_inc = 1'b1;
                        state_d = StAcquire;
                        run_d   = '0;
                    end
                end
                default: begin
                    state_d = StIdle;
                    run_d   = '0;
                end
            endcase
        end
        locked_d = (state_d == StLocked);
    end

`ifdef COUNT_CHECKER_STALL_EN
    // Stall pulse: a repeated sample while acquiring or locked
    always_comb begin
        stall_d = en && !clear && is_stall && (state_q != StIdle);
    end
`endif

    // State and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            run_q      <= '0;
            prev_q     <= '0;
            expected_q <= '0;
            locked_q   <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            run_q      <= run_d;
            prev_q     <= prev_d;
            expected_q <= expected_d;
            locked_q   <= locked_d;
            err_q      <= err_d;
        end
    end

`ifdef COUNT_CHECKER_STALL_EN
    // Stall pulse register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_q <= 1'b0;
        end else begin
            stall_q <= stall_d;
        end
    end

    assign stall_pulse = stall_q;
`endif

    sat_counter #(
        .W (STAT_W)
    ) u_err_count (
        .clk   (clk),
        .rst_n (rst_n),
        .clear (clear),
        .inc   (err_inc),
        .value (err_count)
    );

    sat_counter #(
        .W (STAT_W)
    ) u_wrap_count (
        .clk   (clk),
        .rst_n (rst_n),
        .clear (clear),
        .inc   (wrap_inc),
        .value (wrap_count)
    );

    assign locked    = locked_q;
    assign err_pulse = err_q;
    assign expected  = expected_q;

endmodule
